// File: rtl/regfile_sequencer_pkg.sv
// Shared types and constants for the register-file sequencer slice.
// Holds the FSM encoding, register index/select widths, write-source codes and requester IDs.
package regfile_seq_pkg;

  localparam int NREGS = 16;
  localparam int IDX_W = $clog2(NREGS);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [NREGS-1:0] sel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_LOAD
  } state_e;

  localparam logic WSRC_ALU = 1'b0;
  localparam logic WSRC_LD  = 1'b1;

  typedef enum logic {
    EX = 1'b0,
    LD = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Requester, ALU and register-file control signals between the sequencer and its environment.
// The slave modport is the sequencer's view of these signals; the master modport is the environment's view.
interface regfile_sequencer_if;
  import regfile_seq_pkg::*;

  logic ex_req;
  idx_t ex_rd;
  idx_t ex_rn;
  idx_t ex_rm;
  logic ex_wb;
  logic ex_gnt;
  logic ld_req;
  idx_t ld_rd;
  logic ld_gnt;
  sel_t rd_sel_a;
  sel_t rd_sel_b;
  sel_t wr_sel;
  logic we;
  logic wsrc;
  logic alu_start;
  logic alu_done;
  logic busy;
  logic done;
  logic err;

  modport slave (
    input  ex_req, ex_rd, ex_rn, ex_rm, ex_wb, ld_req, ld_rd, alu_done,
    output ex_gnt, ld_gnt, rd_sel_a, rd_sel_b, wr_sel, we, wsrc, alu_start, busy, done, err
  );

  modport master (
    output ex_req, ex_rd, ex_rn, ex_rm, ex_wb, ld_req, ld_rd, alu_done,
    input  ex_gnt, ld_gnt, rd_sel_a, rd_sel_b, wr_sel, we, wsrc, alu_start, busy, done, err
  );

endinterface

// File: rtl/regfile_sequencer_onehot_dec.sv
// Register index to one-hot select decoder with enable.
// The output is all zeros whenever the enable is low.
module onehot_dec
  import regfile_seq_pkg::*;
(
  input  logic en,
  input  idx_t idx,
  output sel_t sel
);

  always_comb begin
    sel = '0;
    if (en) sel[idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Arbitrates the register file between the execute path and the operand loader.
// Sequences read, ALU and writeback phases so each bus has at most one driver.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int ALU_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_sequencer_if.slave   bus
);

  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

  state_e           state_q, state_d;
  idx_t             rn_q, rn_d, rm_q, rm_d, wr_idx_q, wr_idx_d;
  logic             wb_q, wb_d;
  req_id_e          last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d;
  logic             grant_ex, grant_ld;
  logic             rd_en, wr_en, timeout;

  assign timeout = (cnt_q == CNT_W'(ALU_TIMEOUT - 1));

  // Grants are combinational in IDLE; gating with rst_n keeps them low during reset.
  always_comb begin
    grant_ex = 1'b0;
    grant_ld = 1'b0;
    if (rst_n && state_q == S_IDLE) begin
      if (bus.ex_req && bus.ld_req) begin
        grant_ex = (last_q == LD);
        grant_ld = (last_q == EX);
      end else begin
        grant_ex = bus.ex_req;
        grant_ld = bus.ld_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_ex)      state_d = S_READ;
        else if (grant_ld) state_d = S_LOAD;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        if (bus.alu_done) state_d = wb_q ? S_WB : S_IDLE;
        else if (timeout) state_d = S_IDLE;
      end
      S_WB:    state_d = S_IDLE;
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en         = (state_q == S_READ);
    wr_en         = (state_q == S_WB) || (state_q == S_LOAD);
    bus.we        = wr_en;
    bus.wsrc      = (state_q == S_LOAD) ? WSRC_LD : WSRC_ALU;
    bus.alu_start = (state_q == S_EXEC) && (cnt_q == '0);
    bus.busy      = (state_q != S_IDLE);
    bus.ex_gnt    = grant_ex;
    bus.ld_gnt    = grant_ld;
    bus.done      = done_q;
    bus.err       = err_q;
  end

  // Request fields, round-robin history, ALU wait counter and completion pulses.
  always_comb begin
    rn_d     = rn_q;
    rm_d     = rm_q;
    wr_idx_d = wr_idx_q;
    wb_d     = wb_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    if (grant_ex) begin
      rn_d     = bus.ex_rn;
      rm_d     = bus.ex_rm;
      wr_idx_d = bus.ex_rd;
      wb_d     = bus.ex_wb;
      last_d   = EX;
    end else if (grant_ld) begin
      wr_idx_d = bus.ld_rd;
      last_d   = LD;
    end
    if (state_q == S_READ)      cnt_d = '0;
    else if (state_q == S_EXEC) cnt_d = cnt_q + 1'b1;
    done_d = (state_q == S_WB) || (state_q == S_LOAD) ||
             ((state_q == S_EXEC) && bus.alu_done && !wb_q);
    err_d  = (state_q == S_EXEC) && !bus.alu_done && timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rn_q     <= '0;
      rm_q     <= '0;
      wr_idx_q <= '0;
      wb_q     <= 1'b0;
      last_q   <= LD;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      wr_idx_q <= wr_idx_d;
      wb_q     <= wb_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  onehot_dec u_dec_a (.en(rd_en), .idx(rn_q),     .sel(bus.rd_sel_a));
  onehot_dec u_dec_b (.en(rd_en), .idx(rm_q),     .sel(bus.rd_sel_b));
  onehot_dec u_dec_w (.en(wr_en), .idx(wr_idx_q), .sel(bus.wr_sel));

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-schedule reference model.
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  localparam int T = 15;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
  localparam logic [3:0] Z = 4'd0;
  localparam logic [15:0] N = 16'h0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_sequencer_if bus();

  regfile_sequencer #(.ALU_TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic ex_req; logic [3:0] ex_rd, ex_rn, ex_rm; logic ex_wb;
    logic ld_req; logic [3:0] ld_rd; logic alu_done;
    logic e_exg, e_ldg; logic [15:0] e_sa, e_sb, e_ws;
    logic e_we, e_wsrc, e_st, e_busy, e_done, e_err;
  } vec_t;

  // One expected cycle of an operation already granted.
  typedef struct packed {
    logic [15:0] sa, sb, ws;
    logic we, wsrc, st, is_exec, adone, fin_done, fin_err;
  } slot_t;

  vec_t  vt [16];
  slot_t sq [$];
  int    glog [$];
  logic  m_last_ex, m_done, m_err;
  bit    ex_pend, ld_pend, auto_gen;
  logic [3:0] p_rd, p_rn, p_rm, p_ld;
  logic  p_wb;
  int    p_lat;
  int    cyc = 0;
  int    start_cyc, err_cyc, code, saved_start;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_out();
    return {8'h00, bus.ex_gnt, bus.ld_gnt, bus.rd_sel_a, bus.rd_sel_b, bus.wr_sel,
            bus.we, bus.wsrc, bus.alu_start, bus.busy, bus.done, bus.err};
  endfunction

  function automatic logic [63:0] mk_out(input logic eg, input logic lg, input logic [15:0] sa,
      input logic [15:0] sb, input logic [15:0] ws, input logic we, input logic wsrc,
      input logic st, input logic busy, input logic dn, input logic er);
    return {8'h00, eg, lg, sa, sb, ws, we, wsrc, st, busy, dn, er};
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] i);
    logic [15:0] one;
    one = 16'h0001;
    return one << i;
  endfunction

  task automatic plan_ex(input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                         input logic wb, input int lat);
    slot_t s;
    int n;
    s = '0; s.sa = oh(rn); s.sb = oh(rm);
    sq.push_back(s);
    n = (lat < T) ? lat + 1 : T;
    for (int i = 0; i < n; i++) begin
      s = '0; s.is_exec = 1'b1; s.st = (i == 0); s.adone = (i == lat);
      if (i == n - 1) begin
        if (lat >= T) s.fin_err = 1'b1;
        else if (!wb) s.fin_done = 1'b1;
      end
      sq.push_back(s);
    end
    if (lat < T && wb) begin
      s = '0; s.ws = oh(rd); s.we = 1'b1; s.fin_done = 1'b1;
      sq.push_back(s);
    end
  endtask

  task automatic plan_ld(input logic [3:0] rd);
    slot_t s;
    s = '0; s.ws = oh(rd); s.we = 1'b1; s.wsrc = 1'b1; s.fin_done = 1'b1;
    sq.push_back(s);
  endtask

  task automatic step();
    slot_t cur;
    logic eg, lg, busy_e, ed, ee;
    @(posedge clk); #1;
    cyc++;
    ed = m_done; ee = m_err; m_done = 1'b0; m_err = 1'b0;
    eg = 1'b0; lg = 1'b0; cur = '0; busy_e = 1'b0;
    if (sq.size() > 0) begin
      cur = sq.pop_front();
      busy_e = 1'b1; m_done = cur.fin_done; m_err = cur.fin_err;
    end else if (ex_pend && (!ld_pend || !m_last_ex)) eg = 1'b1;
    else if (ld_pend) lg = 1'b1;
    bus.ex_req = ex_pend; bus.ex_rd = p_rd; bus.ex_rn = p_rn; bus.ex_rm = p_rm; bus.ex_wb = p_wb;
    bus.ld_req = ld_pend; bus.ld_rd = p_ld;
    bus.alu_done = cur.is_exec ? cur.adone : 1'($urandom_range(0, 1));
    #1;
    chk($sformatf("cyc%0d", cyc), dut_out(),
        mk_out(eg, lg, cur.sa, cur.sb, cur.ws, cur.we, cur.wsrc, cur.st, busy_e, ed, ee));
    if (bus.alu_start) start_cyc = cyc;
    if (bus.err) err_cyc = cyc;
    if (bus.ex_gnt) glog.push_back(1);
    if (bus.ld_gnt) glog.push_back(2);
    if (eg) begin plan_ex(p_rd, p_rn, p_rm, p_wb, p_lat); ex_pend = 0; m_last_ex = 1'b1; end
    if (lg) begin plan_ld(p_ld); ld_pend = 0; m_last_ex = 1'b0; end
    if (auto_gen && sq.size() > 0 && $urandom_range(0, 9) == 0) ex_pend = 0;
    if (!ex_pend) begin
      p_rd = 4'($urandom_range(0, 15)); p_rn = 4'($urandom_range(0, 15));
      p_rm = 4'($urandom_range(0, 15)); p_wb = 1'($urandom_range(0, 1));
      p_lat = $urandom_range(0, T + 2);
      if (auto_gen && $urandom_range(0, 2) == 0) ex_pend = 1;
    end
    if (!ld_pend) begin
      p_ld = 4'($urandom_range(0, 15));
      if (auto_gen && $urandom_range(0, 3) == 0) ld_pend = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", dut_out(), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sq.delete();
    m_done = 1'b0; m_err = 1'b0; m_last_ex = 1'b0;
    ex_pend = 0; ld_pend = 0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 80 && (ex_pend || ld_pend || sq.size() > 0); k++) step();
    chk(name, {61'h0, ex_pend, ld_pend, (sq.size() > 0)}, 64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{O,Z,Z,Z,O, I,4'd3,O, O,I, N,N,N,            O,O,O,O,O,O};
    vt[1]  = '{O,Z,Z,Z,O, O,Z,O,    O,O, N,N,16'h0008,     I,I,O,I,O,O};
    vt[2]  = '{O,Z,Z,Z,O, O,Z,O,    O,O, N,N,N,            O,O,O,O,I,O};
    vt[3]  = '{I,4'd5,4'd1,4'd2,I, O,Z,O, I,O, N,N,N,       O,O,O,O,O,O};
    vt[4]  = '{O,Z,Z,Z,O, O,Z,O,    O,O, 16'h0002,16'h0004,N, O,O,O,I,O,O};
    vt[5]  = '{O,Z,Z,Z,O, O,Z,O,    O,O, N,N,N,            O,O,I,I,O,O};
    vt[6]  = '{O,Z,Z,Z,O, O,Z,O,    O,O, N,N,N,            O,O,O,I,O,O};
    vt[7]  = '{O,Z,Z,Z,O, O,Z,O,    O,O, N,N,N,            O,O,O,I,O,O};
    vt[8]  = '{O,Z,Z,Z,O, O,Z,I,    O,O, N,N,N,            O,O,O,I,O,O};
    vt[9]  = '{O,Z,Z,Z,O, O,Z,O,    O,O, N,N,16'h0020,     I,O,O,I,O,O};
    vt[10] = '{O,Z,Z,Z,O, O,Z,O,    O,O, N,N,N,            O,O,O,O,I,O};
    vt[11] = '{I,4'd9,4'd7,4'd7,O, O,Z,O, I,O, N,N,N,       O,O,O,O,O,O};
    vt[12] = '{O,Z,Z,Z,O, O,Z,O,    O,O, 16'h0080,16'h0080,N, O,O,O,I,O,O};
    vt[13] = '{O,Z,Z,Z,O, O,Z,I,    O,O, N,N,N,            O,O,I,I,O,O};
    vt[14] = '{O,Z,Z,Z,O, O,Z,O,    O,O, N,N,N,            O,O,O,O,I,O};
    vt[15] = '{O,Z,Z,Z,O, O,Z,O,    O,O, N,N,N,            O,O,O,O,O,O};

    auto_gen = 0; ex_pend = 0; ld_pend = 0;
    p_rd = Z; p_rn = Z; p_rm = Z; p_ld = Z; p_wb = O; p_lat = 0;
    m_last_ex = 1'b0; m_done = 1'b0; m_err = 1'b0;
    start_cyc = -1; err_cyc = -1;
    rst_n = 1'b0;
    bus.ex_req = I; bus.ex_rd = Z; bus.ex_rn = Z; bus.ex_rm = Z; bus.ex_wb = O;
    bus.ld_req = I; bus.ld_rd = Z; bus.alu_done = O;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_out(), 64'h0);
    bus.ex_req = O; bus.ld_req = O;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus.ex_req = vt[i].ex_req; bus.ex_rd = vt[i].ex_rd; bus.ex_rn = vt[i].ex_rn;
      bus.ex_rm = vt[i].ex_rm; bus.ex_wb = vt[i].ex_wb; bus.ld_req = vt[i].ld_req;
      bus.ld_rd = vt[i].ld_rd; bus.alu_done = vt[i].alu_done;
      #1;
      chk($sformatf("vec%0d", i), dut_out(),
          mk_out(vt[i].e_exg, vt[i].e_ldg, vt[i].e_sa, vt[i].e_sb, vt[i].e_ws, vt[i].e_we,
                 vt[i].e_wsrc, vt[i].e_st, vt[i].e_busy, vt[i].e_done, vt[i].e_err));
    end

    // Simultaneous requests after reset: EX, LD, then both again -> EX, LD.
    do_reset();
    glog.delete();
    p_lat = 2; p_wb = 1; ex_pend = 1; ld_pend = 1;
    for (int k = 0; k < 60 && glog.size() < 2; k++) step();
    p_lat = 0; ex_pend = 1; ld_pend = 1;
    drain("tie_drain");
    code = 0;
    foreach (glog[i]) code = code * 10 + glog[i];
    chk("tie_order", 64'(code), 64'd1212);

    // ALU never answers: err after T EXEC cycles, then a load is served.
    start_cyc = -1; err_cyc = -1;
    p_lat = 99; p_wb = 1; ex_pend = 1;
    for (int k = 0; k < 20 && ex_pend; k++) step();
    ld_pend = 1;
    drain("timeout_drain");
    chk("timeout_gap", 64'(err_cyc - start_cyc), 64'(T));

    // Reset during EXEC: no stale start, writeback or done afterwards.
    p_lat = 99; p_wb = 1; ex_pend = 1;
    for (int k = 0; k < 20 && ex_pend; k++) step();
    repeat (3) step();
    saved_start = start_cyc;
    do_reset();
    repeat (6) step();
    chk("no_stale_start", 64'(start_cyc), 64'(saved_start));

    auto_gen = 1;
    repeat (1500) step();
    auto_gen = 0;
    drain("random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
